// File: rtl/issueq_int_pkg.sv
// Shared widths, the queue-slot record and the CDB snoop helper for the integer issue queue.
// Opcode values themselves are owned by the dispatch unit; only the width lives here.
package issueq_int_pkg;

  localparam int TAG_W   = 6;
  localparam int DATA_W  = 32;
  localparam int IMM_W   = 16;
  localparam int INTOP_W = 4;

  typedef struct packed {
    logic [INTOP_W-1:0] opcode;
    logic [IMM_W-1:0]   imm;
    logic [TAG_W-1:0]   rdtag;
    logic [TAG_W-1:0]   rstag;
    logic [TAG_W-1:0]   rttag;
    logic [DATA_W-1:0]  rsdata;
    logic [DATA_W-1:0]  rtdata;
    logic               rsvalid;
    logic               rtvalid;
  } iq_entry_t;

  // Capture broadcast data into whichever pending operand(s) carry the broadcast tag.
  function automatic iq_entry_t cdb_snoop(
    input iq_entry_t          e,
    input logic               cv,
    input logic [TAG_W-1:0]   ct,
    input logic [DATA_W-1:0]  cd
  );
    iq_entry_t r;
    r = e;
    if (cv && !e.rsvalid && (e.rstag == ct)) begin
      r.rsdata  = cd;
      r.rsvalid = 1'b1;
    end
    if (cv && !e.rtvalid && (e.rttag == ct)) begin
      r.rtdata  = cd;
      r.rtvalid = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/issueq_entry.sv
// One issue-queue slot: holds an instruction, snoops the CDB for its pending operands and
// reloads either from the dispatch bus or from the slot above it when the queue shifts down.
module issueq_entry
  import issueq_int_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              load_new,
  input  iq_entry_t         new_entry,
  input  logic              load_nb,
  input  logic              nb_valid,
  input  iq_entry_t         nb_entry,
  output logic              valid,
  output logic              ready,
  output iq_entry_t         cur,
  output iq_entry_t         snooped
);

  iq_entry_t cur_q;
  logic      valid_q;

  // Post-capture view of this slot; the slot below loads this when the queue shifts.
  assign snooped = cdb_snoop(cur_q, cdb_valid & valid_q, cdb_tag, cdb_data);

  assign valid = valid_q;
  assign ready = valid_q & cur_q.rsvalid & cur_q.rtvalid;
  assign cur   = cur_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      cur_q   <= '0;
    end else if (load_new) begin
      valid_q <= 1'b1;
      cur_q   <= cdb_snoop(new_entry, cdb_valid, cdb_tag, cdb_data);
    end else if (load_nb) begin
      valid_q <= nb_valid;
      cur_q   <= nb_valid ? nb_entry : '0;
    end else begin
      cur_q   <= snooped;
    end
  end

endmodule

// File: rtl/issueq_int.sv
// Integer issue queue: age-ordered shifting array (slot 0 oldest) that issues the oldest
// entry with both operands available to the integer execution unit.
module issueq_int
  import issueq_int_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IMM_W-1:0]   equeue_imm,
  input  logic [TAG_W-1:0]   equeue_rdtag,
  input  logic [TAG_W-1:0]   equeue_rstag,
  input  logic [TAG_W-1:0]   equeue_rttag,
  input  logic [DATA_W-1:0]  equeue_rsdata,
  input  logic [DATA_W-1:0]  equeue_rtdata,
  input  logic               equeue_rsvalid,
  input  logic               equeue_rtvalid,
  input  logic [INTOP_W-1:0] equeueint_opcode,
  input  logic               equeueint_en,
  output logic               equeueint_ready,
  input  logic [TAG_W-1:0]   cdb_tag,
  input  logic               cdb_valid,
  input  logic [DATA_W-1:0]  cdb_data,
  input  logic               issueint_ready,
  output logic               issueint_valid,
  output logic [INTOP_W-1:0] issueint_opcode,
  output logic [DATA_W-1:0]  issueint_rsdata,
  output logic [DATA_W-1:0]  issueint_rtdata,
  output logic [IMM_W-1:0]   issueint_imm,
  output logic [TAG_W-1:0]   issueint_rdtag
);

  // Handshakes: a transfer happens at a rising edge where valid and ready are both high.
  // equeueint_ready comes only from the registered count, so a full queue refuses dispatch
  // even when an issue frees a slot that same cycle. issueint_valid never waits on ready.

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] wr_idx;
  logic [CNT_W-1:0] sel_idx;
  logic             sel_any;
  logic             do_enq;
  logic             do_issue;
  iq_entry_t        new_entry;
  iq_entry_t        sel_e;

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_rdy;
  logic [DEPTH-1:0] load_new;
  logic [DEPTH-1:0] load_nb;
  logic [DEPTH-1:0] nb_valid;
  iq_entry_t        cur_e [DEPTH];
  iq_entry_t        snp_e [DEPTH];
  iq_entry_t        nb_e  [DEPTH];

  assign equeueint_ready = (count != CNT_W'(DEPTH));
  assign do_enq          = equeueint_en & equeueint_ready;
  assign do_issue        = sel_any & issueint_ready;
  // An issue always removes an occupied slot, so the free slot drops by one.
  assign wr_idx          = do_issue ? (count - CNT_W'(1)) : count;

  assign new_entry.opcode  = equeueint_opcode;
  assign new_entry.imm     = equeue_imm;
  assign new_entry.rdtag   = equeue_rdtag;
  assign new_entry.rstag   = equeue_rstag;
  assign new_entry.rttag   = equeue_rttag;
  assign new_entry.rsdata  = equeue_rsdata;
  assign new_entry.rtdata  = equeue_rtdata;
  assign new_entry.rsvalid = equeue_rsvalid;
  assign new_entry.rtvalid = equeue_rtvalid;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    assign load_new[g] = do_enq && (wr_idx == CNT_W'(g));
    assign load_nb[g]  = do_issue && (CNT_W'(g) >= sel_idx);

    if (g == DEPTH - 1) begin : g_top
      assign nb_e[g]     = '0;
      assign nb_valid[g] = 1'b0;
    end else begin : g_mid
      assign nb_e[g]     = snp_e[g+1];
      assign nb_valid[g] = ent_valid[g+1];
    end

    issueq_entry u_entry (
      .clk       (clk),
      .reset     (reset),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .load_new  (load_new[g]),
      .new_entry (new_entry),
      .load_nb   (load_nb[g]),
      .nb_valid  (nb_valid[g]),
      .nb_entry  (nb_e[g]),
      .valid     (ent_valid[g]),
      .ready     (ent_rdy[g]),
      .cur       (cur_e[g]),
      .snooped   (snp_e[g])
    );
  end

  // Slot 0 never feeds a neighbour; its snooped view is only consumed internally.
  logic unused_snp0;
  assign unused_snp0 = ^snp_e[0];

  // Oldest-first priority: scanning downwards leaves the lowest ready index.
  always_comb begin
    sel_any = 1'b0;
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_rdy[i]) begin
        sel_any = 1'b1;
        sel_idx = CNT_W'(i);
      end
    end
  end

  always_comb begin
    sel_e = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_any && (sel_idx == CNT_W'(i))) sel_e = cur_e[i];
    end
  end

  logic unused_sel;
  assign unused_sel = ^{sel_e.rstag, sel_e.rttag, sel_e.rsvalid, sel_e.rtvalid};

  assign issueint_valid  = sel_any;
  assign issueint_opcode = sel_e.opcode;
  assign issueint_rsdata = sel_e.rsdata;
  assign issueint_rtdata = sel_e.rtdata;
  assign issueint_imm    = sel_e.imm;
  assign issueint_rdtag  = sel_e.rdtag;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({do_enq, do_issue})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/issueq_int.md
Name: issueq_int

Overview:
- Integer issue queue. It is the receiving end of the dispatch-to-execution-queue interface (equeue_* bus plus the equeueint_en/equeueint_ready handshake).
- Buffers dispatched integer/branch instructions and snoops the CDB to capture pending source operands.
- Issues the oldest instruction whose operands are both valid to the integer execution unit through a valid/ready handshake.

Parameters:
- DEPTH, 4, number of queue entries (2..8).
- CNT_W, 3, width of the occupancy counter; must hold 0..DEPTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- equeue_imm  in  16  immediate field of the dispatched instruction
- equeue_rdtag  in  6  destination tag
- equeue_rstag  in  6  rs producer tag
- equeue_rttag  in  6  rt producer tag
- equeue_rsdata  in  32  rs value; meaningful when rsvalid=1
- equeue_rtdata  in  32  rt value; meaningful when rtvalid=1
- equeue_rsvalid  in  1  rs operand already available
- equeue_rtvalid  in  1  rt operand already available
- equeueint_opcode  in  4  integer ALU opcode
- equeueint_en  in  1  dispatch write request
- equeueint_ready  out  1  queue can accept an entry this cycle
- cdb_tag  in  6  broadcast tag
- cdb_valid  in  1  broadcast valid
- cdb_data  in  32  broadcast data
- issueint_ready  in  1  execution unit accepts an issue
- issueint_valid  out  1  an entry is selected for issue
- issueint_opcode  out  4  selected opcode
- issueint_rsdata  out  32  selected rs value
- issueint_rtdata  out  32  selected rt value
- issueint_imm  out  16  selected immediate
- issueint_rdtag  out  6  selected destination tag

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high. On reset, count=0, all entry valid bits=0 and operand flags=0.
- Reset output values: equeueint_ready=1, issueint_valid=0, all other issueint_* outputs=0.
- Storage: shifting, age-ordered array. Entry 0 is the oldest. Occupied entries are always 0..count-1.
- equeueint_ready = (count != DEPTH). It is combinational from the registered count only. It does not depend on a same-cycle issue, so no enqueue is accepted when the queue is full, even if an issue happens in that cycle.
- Enqueue: occurs when equeueint_en & equeueint_ready. The entry is written at the clock edge.
  - Write index = count, or count-1 when an issue fires in the same cycle and the issued index is below count.
  - equeueint_en while ready=0 is ignored; no state change.
- CDB snoop, every cycle, for every occupied entry: if cdb_valid and an operand flag=0 and that operand's tag equals cdb_tag, capture cdb_data and set the flag at the edge.
  - rs and rt may both match the same broadcast; both are captured.
- CDB snoop on enqueue: the same check is applied to the incoming operand when its rsvalid/rtvalid=0, so a tag broadcast in the enqueue cycle is not lost.
- Select: issueint_valid=1 when any occupied entry has both flags set. The selected entry is the lowest such index (oldest first). The issueint_* outputs are combinational from that entry and are 0 when issueint_valid=0.
- Issue: occurs when issueint_valid & issueint_ready. At the edge the selected entry is removed, entries above it shift down by one (carrying any CDB captures from this cycle), and count decrements.
- Simultaneous enqueue and issue: count is unchanged, and the new entry lands at the top after the shift.
- Latency:
  - Enqueue with both operands valid at edge N: issueint_valid in cycle N+1.
  - CDB capture at edge M: the entry is issuable in cycle M+1.
  - There is no bypass from the CDB straight to the issue outputs.
- Occupancy: count never exceeds DEPTH and never underflows; an issue requires an occupied ready entry.
- Reset mid-operation clears all entries regardless of any in-flight handshakes.

Decomposition:
- globals.vh: add `define widths for TAG (6), DATA (32), IMM (16), INTOP (4). Opcode values are shared with the dispatch unit.
- One sub-module, issueq_entry. It holds a single slot: fields, rs/rt flags, CDB snoop compare and capture, and load-from-input or load-from-neighbour muxing.
- issueq_int instantiates DEPTH copies and adds the count, select priority encoder and handshake logic.

Test Plan:
- Reset, then enqueue opcode 4'h2 with rsvalid=rtvalid=1, rsdata=5, rtdata=7, rdtag=6'd3, issueint_ready=1 -> next cycle issueint_valid=1, rsdata=5, rtdata=7, rdtag=3; the cycle after, issueint_valid=0 and count=0.
- Enqueue an entry with rsvalid=0, rstag=6'd9 -> issueint_valid stays 0. Then cdb_valid=1, cdb_tag=9, cdb_data=32'hABCD -> issueint_valid=1 the following cycle with rsdata=32'hABCD.
- Enqueue with rttag=6'd12, rtvalid=0 in the same cycle as CDB tag 12 with data 32'h55 -> entry is issuable the next cycle with rtdata=32'h55.
- Fill DEPTH=4 entries with issueint_ready=0 -> equeueint_ready=0; a fifth equeueint_en is ignored. Release ready -> the 4 instructions issue in enqueue order, one per cycle.
- Entries A (waiting on tag 20) and B (both operands ready) -> B issues first. After tag 20 is broadcast, A issues, and the shift keeps the ordering intact.
- Full queue with issue and enqueue asserted together -> enqueue is not accepted. Non-full queue with both asserted -> count is unchanged and the new entry sits at the top.
